// File: rtl/uart_byte_rx_if.sv
// Received-byte bus from uart_byte_rx to its consumer; the receiver drives it via the master modport.
interface uart_byte_rx_if;
   logic [7:0] data_byte;
   logic       Rx_Done;
   logic       Frame_Err;
   logic       Parity_Err;
   logic       uart_state;

   modport master (
      output data_byte, Rx_Done, Frame_Err, Parity_Err, uart_state
   );

   modport slave (
      input  data_byte, Rx_Done, Frame_Err, Parity_Err, uart_state
   );
endinterface

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 16x-oversampled 8N1 receiver, Rx_Done ~2 clk + 9.5 bits after the start edge; no backpressure.
// Define UART_RX_PARITY_EN to add one even-parity bit after data bit 7 and drive Parity_Err.
module uart_byte_rx (
   input  logic           Clk,
   input  logic           Rst_n,
   input  logic [2:0]     baud_set,
   input  logic           Rs232_Rx,
   uart_byte_rx_if.master rx_bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t     state_q;
   logic       sync1_q, sync2_q, sync3_q;
   logic [8:0] bps_dr_d, bps_dr_q;
   logic [8:0] div_cnt_q;
   logic [3:0] smp_cnt_q;
   logic [2:0] bit_idx_q;
   logic [1:0] smp_q;
   logic [7:0] shift_q;
   logic [7:0] data_q;
   logic       done_q;
   logic       ferr_q;
   logic       busy_q;
`ifdef UART_RX_PARITY_EN
   logic       par_q;
   logic       perr_q;
`endif

   logic fall;
   logic tick;
   logic at_vote;
   logic at_wrap;
   logic maj;

   always_comb begin
      bps_dr_d = 9'd324;
      case (baud_set)
         3'd0:    bps_dr_d = 9'd324;
         3'd1:    bps_dr_d = 9'd161;
         3'd2:    bps_dr_d = 9'd80;
         3'd3:    bps_dr_d = 9'd53;
         3'd4:    bps_dr_d = 9'd26;
         default: bps_dr_d = 9'd324;
      endcase
   end

   // Two flops to resolve metastability, the third only to detect the falling edge.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         sync3_q <= 1'b1;
      end else begin
         sync1_q <= Rs232_Rx;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign fall    = sync3_q & ~sync2_q;
   assign tick    = busy_q && (div_cnt_q == bps_dr_q);
   assign at_vote = tick && (smp_cnt_q == 4'd8);
   assign at_wrap = tick && (smp_cnt_q == 4'd15);
   // Samples 6 and 7 are stored; the third is the live value on the vote tick.
   assign maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & sync2_q) | (smp_q[1] & sync2_q);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q   <= S_IDLE;
         bps_dr_q  <= 9'd324;
         div_cnt_q <= 9'd0;
         smp_cnt_q <= 4'd0;
         bit_idx_q <= 3'd0;
         smp_q     <= 2'b00;
         shift_q   <= 8'h00;
         data_q    <= 8'h00;
         done_q    <= 1'b0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q     <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         done_q   <= 1'b0;
         ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q   <= 1'b0;
`endif
         bps_dr_q <= bps_dr_d;

         if (busy_q)
            div_cnt_q <= (div_cnt_q == bps_dr_q) ? 9'd0 : div_cnt_q + 9'd1;
         else
            div_cnt_q <= 9'd0;

         if (tick) begin
            smp_cnt_q <= smp_cnt_q + 4'd1;
            if (smp_cnt_q == 4'd6) smp_q[0] <= sync2_q;
            if (smp_cnt_q == 4'd7) smp_q[1] <= sync2_q;
         end

         case (state_q)
            S_IDLE: begin
               if (fall) begin
                  state_q   <= S_START;
                  busy_q    <= 1'b1;
                  div_cnt_q <= 9'd0;
                  smp_cnt_q <= 4'd0;
                  bit_idx_q <= 3'd0;
               end
            end
            S_START: begin
               if (at_vote && maj) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else if (at_wrap) begin
                  state_q <= S_DATA;
               end
            end
            S_DATA: begin
               if (at_vote)
                  shift_q <= {maj, shift_q[7:1]};
               if (at_wrap) begin
                  bit_idx_q <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= S_PARITY;
`else
                     state_q <= S_STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (at_vote) par_q <= maj;
               if (at_wrap) state_q <= S_STOP;
            end
`endif
            // Leave mid-stop-bit so a start edge at the nominal stop end is not missed.
            S_STOP: begin
               if (at_vote) begin
                  data_q  <= shift_q;
                  done_q  <= 1'b1;
                  ferr_q  <= ~maj;
`ifdef UART_RX_PARITY_EN
                  perr_q  <= ^{shift_q, par_q};
`endif
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rx_bus.data_byte  = data_q;
   assign rx_bus.Rx_Done    = done_q;
   assign rx_bus.Frame_Err  = ferr_q;
   assign rx_bus.uart_state = busy_q;
`ifdef UART_RX_PARITY_EN
   assign rx_bus.Parity_Err = perr_q;
`else
   assign rx_bus.Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: frames driven on Rs232_Rx, expected bytes queued and checked on each Rx_Done.
module tb_uart_byte_rx;

   typedef struct {
      logic [7:0] d;
      logic       fe;
      logic       pe;
   } exp_t;

   logic       Clk;
   logic       Rst_n;
   logic [2:0] baud_set;
   logic       Rs232_Rx;
   int         n_total;
   int         n_bad;
   int         n_done;
   exp_t       exp_q[$];

   uart_byte_rx_if bus ();

   uart_byte_rx dut (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .baud_set (baud_set),
      .Rs232_Rx (Rs232_Rx),
      .rx_bus   (bus)
   );

   initial Clk = 1'b0;
   always #10 Clk = ~Clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int bit_clks(input int bs);
      int dr;
      case (bs)
         1:       dr = 161;
         2:       dr = 80;
         3:       dr = 53;
         4:       dr = 26;
         default: dr = 324;
      endcase
      return (dr + 1) * 16;
   endfunction

   task automatic push(input logic [7:0] d, input logic fe, input logic pe);
      exp_t e;
      e.d  = d;
      e.fe = fe;
      e.pe = pe;
      exp_q.push_back(e);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_v, input int bc);
      Rs232_Rx = 1'b0;
      repeat (bc) @(posedge Clk);
      for (int i = 0; i < 8; i++) begin
         Rs232_Rx = b[i];
         repeat (bc) @(posedge Clk);
      end
`ifdef UART_RX_PARITY_EN
      Rs232_Rx = par_v;
      repeat (bc) @(posedge Clk);
`endif
      Rs232_Rx = stop_v;
      repeat (bc) @(posedge Clk);
      Rs232_Rx = 1'b1;
   endtask

   always @(negedge Clk) begin
      if (Rst_n && bus.Rx_Done) begin
         exp_t e;
         n_done++;
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 8'd1, 8'd0);
         end else begin
            e = exp_q.pop_front();
            chk("data_byte", bus.data_byte, e.d);
            chk("frame_err", 8'(bus.Frame_Err), 8'(e.fe));
            chk("parity_err", 8'(bus.Parity_Err), 8'(e.pe));
         end
      end
   end

   initial begin
      int bc;
      n_total  = 0;
      n_bad    = 0;
      n_done   = 0;
      Rst_n    = 1'b0;
      Rs232_Rx = 1'b1;
      baud_set = 3'd4;
      repeat (5) @(negedge Clk);
      chk("rst_data", bus.data_byte, 8'h00);
      chk("rst_done", 8'(bus.Rx_Done), 8'd0);
      chk("rst_ferr", 8'(bus.Frame_Err), 8'd0);
      chk("rst_perr", 8'(bus.Parity_Err), 8'd0);
      chk("rst_state", 8'(bus.uart_state), 8'd0);
      Rst_n = 1'b1;
      repeat (20) @(negedge Clk);

      // 0xA5 at 115200
      bc = bit_clks(4);
      push(8'hA5, 1'b0, 1'b0);
      send_frame(8'hA5, 1'b1, ^8'hA5, bc);
      repeat (2 * bc) @(negedge Clk);
      chk("a5_count", 8'(n_done), 8'd1);
      chk("a5_state", 8'(bus.uart_state), 8'd0);

      // back-to-back 0x00 then 0xFF at 57600
      baud_set = 3'd3;
      bc = bit_clks(3);
      repeat (10) @(negedge Clk);
      push(8'h00, 1'b0, 1'b0);
      push(8'hFF, 1'b0, 1'b0);
      send_frame(8'h00, 1'b1, 1'b0, bc);
      send_frame(8'hFF, 1'b1, 1'b0, bc);
      repeat (2 * bc) @(negedge Clk);
      chk("b2b_count", 8'(n_done), 8'd3);
      chk("b2b_data", bus.data_byte, 8'hFF);

      // 2 us glitch at 115200: false start rejected
      baud_set = 3'd4;
      repeat (10) @(negedge Clk);
      Rs232_Rx = 1'b0;
      repeat (100) @(negedge Clk);
      Rs232_Rx = 1'b1;
      chk("glitch4_busy", 8'(bus.uart_state), 8'd1);
      repeat (500) @(negedge Clk);
      chk("glitch4_idle", 8'(bus.uart_state), 8'd0);
      chk("glitch4_count", 8'(n_done), 8'd3);
      chk("glitch4_data", bus.data_byte, 8'hFF);

      // same glitch at 9600: rejection only after ~9 slow ticks
      baud_set = 3'd0;
      repeat (10) @(negedge Clk);
      Rs232_Rx = 1'b0;
      repeat (100) @(negedge Clk);
      Rs232_Rx = 1'b1;
      repeat (2000) @(negedge Clk);
      chk("glitch0_busy", 8'(bus.uart_state), 8'd1);
      repeat (1500) @(negedge Clk);
      chk("glitch0_idle", 8'(bus.uart_state), 8'd0);
      chk("glitch0_count", 8'(n_done), 8'd3);

      // framing error at 38400
      baud_set = 3'd2;
      bc = bit_clks(2);
      repeat (10) @(negedge Clk);
      push(8'h3C, 1'b1, 1'b0);
      send_frame(8'h3C, 1'b0, ^8'h3C, bc);
      repeat (2 * bc) @(negedge Clk);
      chk("ferr_count", 8'(n_done), 8'd4);
      chk("ferr_data", bus.data_byte, 8'h3C);
      chk("ferr_state", 8'(bus.uart_state), 8'd0);

      // reset during bit 4 of 0x5A, then 0x81
      baud_set = 3'd4;
      bc = bit_clks(4);
      repeat (10) @(negedge Clk);
      Rs232_Rx = 1'b0;
      repeat (bc) @(posedge Clk);
      for (int i = 0; i < 4; i++) begin
         Rs232_Rx = 1'(8'h5A >> i);
         repeat (bc) @(posedge Clk);
      end
      Rs232_Rx = 1'b1;
      repeat (bc / 2) @(posedge Clk);
      Rst_n = 1'b0;
      @(negedge Clk);
      chk("abort_state", 8'(bus.uart_state), 8'd0);
      chk("abort_data", bus.data_byte, 8'h00);
      repeat (bc * 6) @(negedge Clk);
      Rst_n = 1'b1;
      repeat (20) @(negedge Clk);
      chk("abort_count", 8'(n_done), 8'd4);
      push(8'h81, 1'b0, 1'b0);
      send_frame(8'h81, 1'b1, ^8'h81, bc);
      repeat (2 * bc) @(negedge Clk);
      chk("after_rst_count", 8'(n_done), 8'd5);
      chk("after_rst_data", bus.data_byte, 8'h81);

`ifdef UART_RX_PARITY_EN
      push(8'h07, 1'b0, 1'b0);
      send_frame(8'h07, 1'b1, 1'b1, bc);
      repeat (2 * bc) @(negedge Clk);
      push(8'h07, 1'b0, 1'b1);
      send_frame(8'h07, 1'b1, 1'b0, bc);
      repeat (2 * bc) @(negedge Clk);
      chk("par_count", 8'(n_done), 8'd7);
`endif

      chk("queue_empty", 8'(exp_q.size()), 8'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
